// File: rtl/slave_axi_reader_if.sv
// Bus bundle for slave_axi_reader: AXI AW/W/B channels plus the per-beat
// request/response link to the bridge core.
interface slave_axi_reader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [3:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [ID_WIDTH-1:0]   wid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic                  req_valid;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_err;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output req_addr, req_wdata, req_wstrb, req_valid,
    input  req_ready, resp_valid, resp_err
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  req_addr, req_wdata, req_wstrb, req_valid,
    output req_ready, resp_valid, resp_err
  );
endinterface

// File: rtl/slave_axi_reader.sv
// AXI write-channel slave for the AXI-to-APB bridge: splits each AW/W burst
// into single-beat core requests and returns one B response per burst.
module slave_axi_reader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  slave_axi_reader_if.slave bus
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_BRESP
  } state_t;

  state_t state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [3:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  illegal_q;
  logic                  err_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  last_beat;
  logic                  beat_err;
  logic                  wrap_len_ok;
  logic                  aw_illegal;
  logic [ADDR_WIDTH-1:0] aw_align_mask;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Handshake qualifiers and per-burst legality of the incoming AW
  always_comb begin
    aw_hs         = (state_q == S_IDLE) && bus.awvalid && bus.awready;
    w_hs          = (state_q == S_WDATA) && bus.wvalid && bus.wready;
    last_beat     = (cnt_q == len_q);
    beat_err      = (bus.wid != id_q) || (bus.wlast != last_beat);
    aw_align_mask = (ADDR_WIDTH'(1) << bus.awsize) - ADDR_WIDTH'(1);
    wrap_len_ok   = (bus.awlen == 4'd1) || (bus.awlen == 4'd3) ||
                    (bus.awlen == 4'd7) || (bus.awlen == 4'd15);
    aw_illegal    = (bus.awburst == BURST_RSVD) ||
                    (bus.awsize > 3'(MAX_SIZE)) ||
                    ((bus.awburst == BURST_WRAP) &&
                     (!wrap_len_ok || ((bus.awaddr & aw_align_mask) != '0)));
  end

  // Next beat address; for legal WRAP bursts (len+1)<<size is a power of two
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = (ADDR_WIDTH'(len_q) << size_q) | (step - ADDR_WIDTH'(1));
    incr_addr = addr_q + step;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (aw_hs) state_d = S_WDATA;
      S_WDATA: if (w_hs) state_d = illegal_q ? S_NEXT : S_REQ;
      S_REQ:   if (bus.req_ready) state_d = S_WAIT;
      S_WAIT:  if (bus.resp_valid) state_d = S_NEXT;
      S_NEXT:  state_d = last_beat ? S_BRESP : S_WDATA;
      S_BRESP: if (bus.bready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.req_valid <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bid     <= '0;
      bus.bresp   <= RESP_OKAY;
    end else begin
      bus.awready   <= (state_d == S_IDLE);
      bus.wready    <= (state_d == S_WDATA);
      bus.req_valid <= (state_d == S_REQ);
      bus.bvalid    <= (state_d == S_BRESP);
      if ((state_q == S_NEXT) && (state_d == S_BRESP)) begin
        bus.bid   <= id_q;
        bus.bresp <= err_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Burst context, beat counter, error flag and request register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      illegal_q     <= 1'b0;
      err_q         <= 1'b0;
      bus.req_addr  <= '0;
      bus.req_wdata <= '0;
      bus.req_wstrb <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (aw_hs) begin
            id_q      <= bus.awid;
            addr_q    <= bus.awaddr;
            len_q     <= bus.awlen;
            size_q    <= bus.awsize;
            burst_q   <= bus.awburst;
            cnt_q     <= '0;
            illegal_q <= aw_illegal;
            err_q     <= aw_illegal;
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            bus.req_addr  <= addr_q;
            bus.req_wdata <= bus.wdata;
            bus.req_wstrb <= bus.wstrb;
            if (beat_err) err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.resp_valid && bus.resp_err) err_q <= 1'b1;
        end
        S_NEXT: begin
          if (!last_beat) begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/slave_axi_reader.md
# slave_axi_reader

- AXI slave write-channel receiver for the AXI-to-APB bridge. It accepts AW and W traffic from an AXI master and splits each burst into single-beat write requests to the bridge core's APB-side sequencer. It returns one B response per burst.
- It is the write-direction counterpart of the slave read-channel block. Only one burst is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 or 64)
- ID_WIDTH, 4, AXI ID width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- awid  in  ID_WIDTH  write address ID
- awaddr  in  ADDR_WIDTH  start address
- awlen  in  4  beats minus 1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awvalid / awready  in / out  1  AW handshake
- wid  in  ID_WIDTH  write data ID
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wlast  in  1  last beat marker
- wvalid / wready  in / out  1  W handshake
- bid  out  ID_WIDTH  response ID
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid / bready  out / in  1  B handshake
- req_addr  out  ADDR_WIDTH  per-beat address to the core
- req_wdata  out  DATA_WIDTH  per-beat data
- req_wstrb  out  DATA_WIDTH/8  per-beat strobes
- req_valid / req_ready  out / in  1  request handshake
- resp_valid  in  1  core finished the current beat (one-cycle pulse)
- resp_err  in  1  PSLVERR of that beat, qualified by resp_valid

## Operation
- FSM states and transitions:
  - IDLE: awready=1. On AW handshake, capture id, addr, len, size and burst; clear beat counter and error flag; go to WDATA.
  - WDATA: wready=1. On W handshake, latch wdata/wstrb and the current address into the request register, then:
    - if the burst is illegal, skip REQ and go to NEXT;
    - otherwise go to REQ.
  - REQ: req_valid=1; hold all req_* stable. On req_ready go to WAIT.
  - WAIT: on resp_valid, OR resp_err into the error flag, then go to NEXT.
  - NEXT: single cycle. If beat counter == awlen, go to BRESP. Otherwise increment the counter, advance the address, and return to WDATA.
  - BRESP: bvalid=1, bid=captured awid, bresp=10 if error flag else 00. On bready go to IDLE.
- Address advance (step = 1<<awsize):
  - FIXED: address unchanged.
  - INCR: address += step, modulo 2^ADDR_WIDTH.
  - WRAP: burst length L = (awlen+1)*step. Boundary = start address & ~(L-1). Next address = boundary + ((addr + step) & (L-1)).
- Illegal burst: any of the following sets the error flag and suppresses every downstream request for that burst. All beats are still drained and one B response is issued.
  - awburst=11
  - awsize > log2(DATA_WIDTH/8)
  - WRAP with awlen not in {1,3,7,15}
  - WRAP with start address not aligned to step
- Per-beat protocol errors set the error flag but the beat is still forwarded:
  - wid ≠ captured awid
  - wlast=1 on a beat other than the final one
  - wlast=0 on the final beat
- The burst always ends after exactly awlen+1 beats, regardless of wlast.
- req_wstrb is passed through unmodified.

## Timing
- Reset values (asynchronous, while rst=1):
  - state=IDLE, counters and error flag cleared
  - awready=0, wready=0, req_valid=0, bvalid=0
  - bid, bresp, req_addr, req_wdata, req_wstrb all 0
- awready is registered and goes to 1 on the first rising edge after rst deasserts.
- Latencies, with each handshake at edge N:
  - AW handshake at N: wready=1 in cycle N+1.
  - W handshake at N: req_valid=1 in cycle N+1.
  - resp_valid at N: the FSM is in NEXT in cycle N+1. In cycle N+2, wready=1 (next beat) or bvalid=1 (final beat).
  - B handshake at N: awready=1 in cycle N+1.
- Minimum beat period: 4 cycles when req_ready and resp_valid are returned immediately.
- Once asserted, bvalid and req_valid stay high, with payload stable, until their handshake completes.
- resp_valid outside the WAIT state is ignored.
- rst asserted mid-burst abandons the burst:
  - req_valid and bvalid drop immediately;
  - no B response is ever issued for the aborted burst.

## Test plan
- INCR write: awaddr=0x1000, awlen=3, awsize=2, data 0x11..0x44 → req_addr sequence 0x1000, 0x1004, 0x1008, 0x100C; one B response with bid=awid, bresp=00.
- WRAP write: awaddr=0x2008, awlen=3, awsize=2 → req_addr sequence 0x2008, 0x200C, 0x2000, 0x2004.
- resp_err=1 on beat 2 of a 4-beat burst → all 4 beats still forwarded; bresp=10.
- awburst=11, awlen=1 → 2 W beats accepted, req_valid never asserted, bresp=10.
- Backpressure and early wlast:
  - req_ready held low for 5 cycles → req_valid and payload stable throughout;
  - wlast=1 on beat 0 of a 2-beat burst → 2 beats accepted, bresp=10;
  - bready low for 3 cycles → bvalid held; awready returns the cycle after the B handshake.
- rst pulsed while in WAIT → outputs return to reset values immediately; a subsequent 1-beat burst completes with bresp=00.
